// File: rtl/invk2j_feeder.sv
// Coordinate feeder for invk2j: buffers (x,y) pairs and presents one at a time, held for HOLD_CYCLES.
// Optional saturation of popped values is enabled by defining INVK2J_FEEDER_CLAMP_EN.
//
// state | meaning
// IDLE  | FIFO empty, in0/in1 hold the last driven pair
// HOLD  | pair on in0/in1 settling; sample pulses on the final cycle
module invk2j_feeder #(
  parameter int          DEPTH       = 8,
  parameter int          HOLD_CYCLES = 100,
  parameter logic [31:0] CLAMP_MAX   = 32'h7FFF_FFFF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [31:0]                s_x,
  input  logic [31:0]                s_y,
  output logic [31:0]                in0,
  output logic [31:0]                in1,
  output logic                       sample,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(HOLD_CYCLES + 1);

`ifdef INVK2J_FEEDER_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  typedef enum logic {ST_IDLE, ST_HOLD} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [31:0]     in0_q, in0_d;
  logic [31:0]     in1_q, in1_d;
  logic [63:0]     mem_q [DEPTH];

  logic            full;
  logic            nonempty;
  logic            push;
  logic            pop;
  logic [63:0]     head;
  logic [31:0]     load_x;
  logic [31:0]     load_y;

  // Symmetric saturation to [-CLAMP_MAX, +CLAMP_MAX] on signed values.
  function automatic logic [31:0] clamp(input logic [31:0] v);
    logic signed [31:0] sv;
    logic signed [31:0] cmax;
    logic signed [31:0] cmin;
    sv   = v;
    cmax = CLAMP_MAX;
    cmin = -cmax;
    if (sv > cmax) begin
      return cmax;
    end else if (sv < cmin) begin
      return cmin;
    end
    return v;
  endfunction

  assign full     = (level_q == LW'(DEPTH));
  assign nonempty = (level_q != '0);
  assign push     = s_valid && !full;
  assign head     = mem_q[rd_ptr_q];
  assign load_x   = CLAMP_EN ? clamp(head[63:32]) : head[63:32];
  assign load_y   = CLAMP_EN ? clamp(head[31:0])  : head[31:0];

  assign sample  = (state_q == ST_HOLD) && (cnt_q == CW'(1));
  assign busy    = (state_q == ST_HOLD);
  assign s_ready = !full;
  assign level   = level_q;
  assign in0     = in0_q;
  assign in1     = in1_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    in0_d   = in0_q;
    in1_d   = in1_q;
    pop     = 1'b0;

    if (state_q == ST_IDLE) begin
      if (nonempty) begin
        pop     = 1'b1;
        in0_d   = load_x;
        in1_d   = load_y;
        cnt_d   = CW'(HOLD_CYCLES);
        state_d = ST_HOLD;
      end
    end else begin
      cnt_d = cnt_q - CW'(1);
      // Terminal count: hand over to the next pair with no gap, or go quiet.
      if (cnt_q == CW'(1)) begin
        if (nonempty) begin
          pop   = 1'b1;
          in0_d = load_x;
          in1_d = load_y;
          cnt_d = CW'(HOLD_CYCLES);
        end else begin
          state_d = ST_IDLE;
        end
      end
    end

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + LW'(push) - LW'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      in0_q    <= '0;
      in1_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      in0_q    <= in0_d;
      in1_q    <= in1_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {s_x, s_y};
    end
  end

endmodule

// File: tb/tb_invk2j_feeder.sv
// Directed bench for invk2j_feeder: a DEPTH=4/HOLD=4 instance plus a DEPTH=4/HOLD=1 instance.
module tb_invk2j_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic        s_valid = 1'b0;
  logic [31:0] s_x = '0, s_y = '0;
  logic        s_ready, sample, busy;
  logic [31:0] in0, in1;
  logic [2:0]  level;

  logic        s1_valid = 1'b0;
  logic [31:0] s1_x = '0, s1_y = '0;
  logic        s1_ready, sample1, busy1;
  logic [31:0] in0_1, in1_1;
  logic [2:0]  level1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  invk2j_feeder #(.DEPTH(4), .HOLD_CYCLES(4), .CLAMP_MAX(32'h0010_0000)) dut (
    .clk(clk), .rst(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_y(s_y),
    .in0(in0), .in1(in1), .sample(sample), .busy(busy), .level(level));

  invk2j_feeder #(.DEPTH(4), .HOLD_CYCLES(1), .CLAMP_MAX(32'h0010_0000)) dut1 (
    .clk(clk), .rst(rst_n), .s_valid(s1_valid), .s_ready(s1_ready), .s_x(s1_x), .s_y(s1_y),
    .in0(in0_1), .in1(in1_1), .sample(sample1), .busy(busy1), .level(level1));

  typedef struct {
    logic        v;
    logic [31:0] x, y;
    logic        rdy;
    logic [31:0] i0, i1;
    logic        smp, bsy;
    logic [2:0]  lvl;
  } vec_t;

  function automatic vec_t mk(logic v, logic [31:0] x, logic [31:0] y, logic rdy,
                              logic [31:0] i0, logic [31:0] i1, logic smp, logic bsy, logic [2:0] lvl);
    vec_t r;
    r.v = v; r.x = x; r.y = y; r.rdy = rdy; r.i0 = i0; r.i1 = i1;
    r.smp = smp; r.bsy = bsy; r.lvl = lvl;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] AX = 32'h0001_0000, AY = 32'h0002_0000;
  localparam logic [31:0] BX = 32'h0011_0000, BY = 32'h0012_0000;
  localparam logic [31:0] CX = 32'h0021_0000, CY = 32'h0022_0000;

  vec_t tbl [15];
  logic [31:0] gx [$];
  logic [31:0] gy [$];
  logic        bad;
  logic [31:0] exp_cx, exp_cy;

  initial begin
    tbl[0]  = mk(1, AX, AY, 1, 0,  0,  0, 0, 1);
    tbl[1]  = mk(1, BX, BY, 1, AX, AY, 0, 1, 1);
    tbl[2]  = mk(1, CX, CY, 1, AX, AY, 0, 1, 2);
    tbl[3]  = mk(0, 0, 0,   1, AX, AY, 0, 1, 2);
    tbl[4]  = mk(0, 0, 0,   1, AX, AY, 1, 1, 2);
    tbl[5]  = mk(0, 0, 0,   1, BX, BY, 0, 1, 1);
    tbl[6]  = mk(0, 0, 0,   1, BX, BY, 0, 1, 1);
    tbl[7]  = mk(0, 0, 0,   1, BX, BY, 0, 1, 1);
    tbl[8]  = mk(0, 0, 0,   1, BX, BY, 1, 1, 1);
    tbl[9]  = mk(0, 0, 0,   1, CX, CY, 0, 1, 0);
    tbl[10] = mk(0, 0, 0,   1, CX, CY, 0, 1, 0);
    tbl[11] = mk(0, 0, 0,   1, CX, CY, 0, 1, 0);
    tbl[12] = mk(0, 0, 0,   1, CX, CY, 1, 1, 0);
    tbl[13] = mk(0, 0, 0,   1, CX, CY, 0, 0, 0);
    tbl[14] = mk(0, 0, 0,   1, CX, CY, 0, 0, 0);

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in0", in0, 0);
    chk("rst_in1", in1, 0);
    chk("rst_level", level, 0);
    chk("rst_ready", s_ready, 1);
    chk("rst_sample", sample, 0);
    chk("rst_busy", busy, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // Single push then back-to-back pairs, one row per edge
    for (int i = 0; i < 15; i++) begin
      s_valid = tbl[i].v;
      s_x = tbl[i].x;
      s_y = tbl[i].y;
      tick();
      chk($sformatf("seq%0d_in0", i), in0, tbl[i].i0);
      chk($sformatf("seq%0d_in1", i), in1, tbl[i].i1);
      chk($sformatf("seq%0d_sample", i), sample, tbl[i].smp);
      chk($sformatf("seq%0d_busy", i), busy, tbl[i].bsy);
      chk($sformatf("seq%0d_level", i), level, tbl[i].lvl);
      chk($sformatf("seq%0d_ready", i), s_ready, tbl[i].rdy);
    end

    // Overflow: six pairs offered one per edge, the sixth lands while full
    for (int i = 0; i < 45; i++) begin
      s_valid = (i < 6);
      s_x = 32'h3000_0000 + i;
      s_y = 32'h4000_0000 + i;
      tick();
      if (sample) begin
        gx.push_back(in0);
        gy.push_back(in1);
      end
      if (i == 4) begin
        chk("ovf_full_level", level, 4);
        chk("ovf_full_ready", s_ready, 0);
      end
      if (i == 5) chk("ovf_after_drop_level", level, 3);
    end
    s_valid = 1'b0;
    chk("ovf_sample_count", gx.size(), 5);
    for (int k = 0; k < 5; k++) begin
      if (k < gx.size()) begin
        chk($sformatf("ovf_order%0d_x", k), gx[k], 32'h3000_0000 + k);
        chk($sformatf("ovf_order%0d_y", k), gy[k], 32'h4000_0000 + k);
      end
    end
    chk("ovf_drained_level", level, 0);
    chk("ovf_drained_busy", busy, 0);

    // Reset in the middle of a hold with two entries queued
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_x = 32'h50 + i;
      s_y = 32'h60 + i;
      tick();
    end
    s_valid = 1'b0;
    tick();
    chk("mid_hold_level", level, 2);
    chk("mid_hold_in0", in0, 32'h50);
    rst_n = 1'b0;
    #1;
    chk("abort_in0", in0, 0);
    chk("abort_in1", in1, 0);
    chk("abort_level", level, 0);
    chk("abort_sample", sample, 0);
    chk("abort_busy", busy, 0);
    tick();
    chk("abort_sample_hold", sample, 0);
    tick();
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (busy || sample || level != 0 || in0 != 0) bad = 1'b1;
    end
    chk("post_reset_quiet", bad, 0);
    s_valid = 1'b1;
    s_x = 32'h66;
    s_y = 32'h77;
    tick();
    s_valid = 1'b0;
    tick();
    chk("post_reset_in0", in0, 32'h66);
    chk("post_reset_in1", in1, 32'h77);
    chk("post_reset_busy", busy, 1);
    for (int i = 0; i < 6; i++) tick();
    chk("post_reset_idle", busy, 0);

    // Extreme values: saturated when clamping is built in, raw otherwise
`ifdef INVK2J_FEEDER_CLAMP_EN
    exp_cx = 32'h0010_0000;
    exp_cy = 32'hFFF0_0000;
`else
    exp_cx = 32'h7FFF_FFFF;
    exp_cy = 32'h8000_0000;
`endif
    s_valid = 1'b1;
    s_x = 32'h7FFF_FFFF;
    s_y = 32'h8000_0000;
    tick();
    s_valid = 1'b0;
    tick();
    chk("clamp_in0", in0, exp_cx);
    chk("clamp_in1", in1, exp_cy);

    // HOLD_CYCLES=1 continuous stream: new pair and a sample every cycle
    for (int i = 0; i < 10; i++) begin
      s1_valid = (i < 8);
      s1_x = 32'h100 + i;
      s1_y = 32'h200 + i;
      tick();
      if (i >= 1 && i <= 8) begin
        chk($sformatf("h1_%0d_in0", i), in0_1, 32'h100 + i - 1);
        chk($sformatf("h1_%0d_in1", i), in1_1, 32'h200 + i - 1);
        chk($sformatf("h1_%0d_sample", i), sample1, 1);
        chk($sformatf("h1_%0d_ready", i), s1_ready, 1);
      end
      if (i == 9) begin
        chk("h1_end_sample", sample1, 0);
        chk("h1_end_busy", busy1, 0);
        chk("h1_end_in0", in0_1, 32'h107);
      end
    end
    s1_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
